trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap sequencer. Detects ECALL / EBREAK / MRET in execute and
//   pending external interrupts, stalls the pipeline, performs the CSR updates
//   (mepc, mstatus, mcause) one per cycle through the CSR file's secondary
//   write port, then redirects the PC to mtvec (trap) or mepc (MRET).
//
// Ports
//   clk, rst          core clock, asynchronous active-low reset
//   int_flag_i        external interrupt lines (any nonzero = level request)
//   inst_i            instruction in execute
//   inst_addr_i       PC of inst_i
//   jump_flag_i       execute redirects this cycle
//   jump_addr_i       redirect target from execute
//   div_started_i     multi-cycle divider busy
//   global_int_en_i   mstatus.MIE
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i   live CSR values
//   hold_flag_o       pipeline stall request (combinational)
//   we_o, waddr_o, data_o                    CSR write port (registered)
//   int_assert_o, int_addr_o                 one-cycle PC redirect (registered)
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] INT_CAUSE    = 32'h8000_0004,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_started_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_ASSERT,
    S_MRET_MSTATUS,
    S_MRET_ASSERT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;
  logic        hold;

  logic is_ecall, is_ebreak, is_mret, int_pending;

  assign is_ecall    = (inst_i == INST_ECALL);
  assign is_ebreak   = (inst_i == INST_EBREAK);
  assign is_mret     = (inst_i == INST_MRET);
  assign int_pending = (int_flag_i != 8'h00) && global_int_en_i;

  // Next-state, latched trap context and stall request.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    hold    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (is_ecall || is_ebreak) begin
          // Context is captured now even if we must wait for the divider.
          hold    = 1'b1;
          cause_d = is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
          epc_d   = inst_addr_i;
          state_d = div_started_i ? S_WAIT : S_W_MEPC;
        end else if (int_pending && !div_started_i) begin
          // A redirecting instruction has already retired; resume at its target.
          hold    = 1'b1;
          cause_d = INT_CAUSE;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          state_d = S_W_MEPC;
        end else if (is_mret) begin
          hold    = 1'b1;
          state_d = S_MRET_MSTATUS;
        end
      end
      S_WAIT:         if (!div_started_i) state_d = S_W_MEPC;
      S_W_MEPC:       state_d = S_W_MSTATUS;
      S_W_MSTATUS:    state_d = S_W_MCAUSE;
      S_W_MCAUSE:     state_d = S_ASSERT;
      S_ASSERT:       state_d = S_IDLE;
      S_MRET_MSTATUS: state_d = S_MRET_ASSERT;
      S_MRET_ASSERT:  state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and registered, so each
  // strobe is valid exactly during the cycle its state is occupied.
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;

    case (state_d)
      S_W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      S_W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                   1'b0, csr_mstatus_i[2:0]};
      end
      S_W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_d;
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_MRET_MSTATUS: begin
        // MIE <= MPIE, MPIE <= 1
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                   csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      S_MRET_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign hold_flag_o  = hold;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Scoreboard bench for trap_ctrl. Stimulus tasks compute the architectural
//   effect of each trap / MRET from the privileged-spec rules and push the
//   expected CSR writes and redirect (with the cycle they must appear in) into
//   a queue; an independent monitor pops and compares whenever the DUT shows a
//   write or redirect. The bench also plays the CSR file: it owns mstatus /
//   mepc / mtvec and drives them back into the DUT.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam logic [1:0] K_WRITE  = 2'b10;
  localparam logic [1:0] K_REDIR  = 2'b01;

  localparam int T_ECALL = 0, T_EBREAK = 1, T_INT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_started_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  // CSR file state owned by the bench
  logic [31:0] mstatus_m, mepc_m, mtvec_m;
  assign csr_mstatus_i   = mstatus_m;
  assign csr_mepc_i      = mepc_m;
  assign csr_mtvec_i     = mtvec_m;
  assign global_int_en_i = mstatus_m[3];

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .int_flag_i      (int_flag_i),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .div_started_i   (div_started_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .hold_flag_o     (hold_flag_o),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .data_o          (data_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [1:0] k,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per write/redirect the DUT presents.
  always @(negedge clk) begin
    if (rst) begin
      if (we_o || int_assert_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {62'd0, we_o, int_assert_o}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("out_kind",  {62'd0, we_o, int_assert_o}, {62'd0, mon_e.kind});
          check("out_addr",  {32'd0, (we_o ? waddr_o : int_addr_o)}, {32'd0, mon_e.addr});
          check("out_data",  {32'd0, data_o}, {32'd0, mon_e.data});
        end
      end
      if (!we_o)         check("idle_write_bus_zero", {waddr_o, data_o}, 64'd0);
      if (!int_assert_o) check("idle_redirect_zero", {32'd0, int_addr_o}, 64'd0);
    end
  end

  // One clock cycle: check the combinational stall mid-cycle, then advance.
  task automatic tick(input logic exp_hold, input string name);
    @(negedge clk);
    #1;
    check(name, {63'd0, hold_flag_o}, {63'd0, exp_hold});
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    inst_i        = NOP;
    int_flag_i    = 8'h00;
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    div_started_i = 1'b0;
  endtask

  task automatic idle(input int n, input string name);
    inst_i = NOP;
    repeat (n) tick(1'b0, name);
  endtask

  // Full trap: optional cycles where an interrupt is blocked by the divider
  // (pre_div), optional WAIT cycles for a synchronous trap (post_div).
  task automatic trap_seq(input int kind, input logic [31:0] pc, input logic [7:0] intf,
                          input logic jf, input logic [31:0] ja,
                          input int pre_div, input int post_div, input logic keep_int);
    logic [31:0] cause, epc, ms_new;
    int unsigned n;
    cause  = (kind == T_ECALL) ? 32'd11 : (kind == T_EBREAK) ? 32'd3 : 32'h8000_0004;
    epc    = (kind == T_INT && jf) ? ja : pc;
    ms_new = mstatus_m;
    ms_new[7] = mstatus_m[3];
    ms_new[3] = 1'b0;

    inst_i     = NOP;
    int_flag_i = intf;
    for (int i = 0; i < pre_div; i++) begin
      div_started_i = 1'b1;
      tick(1'b0, "hold_int_blocked_by_div");
    end

    inst_i        = (kind == T_ECALL) ? ECALL : (kind == T_EBREAK) ? EBREAK : NOP;
    inst_addr_i   = pc;
    jump_flag_i   = jf;
    jump_addr_i   = ja;
    div_started_i = (post_div > 0);
    n = cyc + post_div;
    push(n + 1, K_WRITE, 32'h341, epc);
    push(n + 2, K_WRITE, 32'h300, ms_new);
    push(n + 3, K_WRITE, 32'h342, cause);
    push(n + 4, K_REDIR, mtvec_m, 32'h0);
    tick(1'b1, "hold_accept");

    // Context must have been captured in the accepting cycle.
    inst_i      = NOP;
    inst_addr_i = $urandom;
    jump_flag_i = 1'b0;
    if (!keep_int) int_flag_i = 8'h00;
    for (int i = 1; i <= post_div; i++) begin
      div_started_i = (i < post_div);
      tick(1'b1, "hold_wait");
    end
    div_started_i = 1'b0;
    repeat (4) tick(1'b1, "hold_seq");
    mstatus_m = ms_new;
    mepc_m    = epc;
  endtask

  task automatic mret_seq();
    logic [31:0] ms_new;
    int unsigned n;
    ms_new = mstatus_m;
    ms_new[3] = mstatus_m[7];
    ms_new[7] = 1'b1;
    inst_i = MRET;
    n = cyc;
    push(n + 1, K_WRITE, 32'h300, ms_new);
    push(n + 2, K_REDIR, mepc_m, 32'h0);
    tick(1'b1, "hold_mret_accept");
    inst_i = NOP;
    tick(1'b1, "hold_mret_seq");
    tick(1'b1, "hold_mret_seq");
    mstatus_m = ms_new;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int op;
    set_nop();
    inst_addr_i = 32'h0;
    mstatus_m   = 32'h0;
    mepc_m      = 32'h0;
    mtvec_m     = 32'h0;
    rst         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_we",        {63'd0, we_o}, 64'd0);
    check("reset_int_assert", {63'd0, int_assert_o}, 64'd0);
    check("reset_bus",       {waddr_o, data_o}, 64'd0);
    check("reset_int_addr",  {32'd0, int_addr_o}, 64'd0);
    check("reset_hold",      {63'd0, hold_flag_o}, 64'd0);
    rst = 1'b1;
    idle(2, "hold_idle_after_reset");

    // ECALL at 0x100, mstatus=0x8, mtvec=0x400
    mstatus_m = 32'h8;
    mtvec_m   = 32'h400;
    trap_seq(T_ECALL, 32'h100, 8'h00, 1'b0, 32'h0, 0, 0, 1'b0);
    idle(1, "hold_idle");

    // Interrupt while execute is redirecting
    mstatus_m = 32'h8;
    idle(1, "hold_idle");
    trap_seq(T_INT, 32'h180, 8'h01, 1'b1, 32'h200, 0, 0, 1'b0);
    idle(1, "hold_idle");

    // ECALL with divider busy for 3 cycles
    trap_seq(T_ECALL, 32'h240, 8'h00, 1'b0, 32'h0, 0, 3, 1'b0);
    idle(1, "hold_idle");

    // MRET with mstatus=0x80, mepc=0x104
    mstatus_m = 32'h80;
    mepc_m    = 32'h104;
    idle(1, "hold_idle");
    mret_seq();
    idle(1, "hold_idle");

    // ECALL and interrupt together; interrupt stays masked until MRET, then
    // is taken in the first idle cycle after the redirect.
    mstatus_m = 32'h8;
    idle(1, "hold_idle");
    trap_seq(T_ECALL, 32'h300, 8'h01, 1'b0, 32'h0, 0, 0, 1'b1);
    idle(3, "hold_int_masked");
    mret_seq();
    trap_seq(T_INT, 32'h380, 8'h01, 1'b0, 32'h0, 0, 0, 1'b0);
    idle(1, "hold_idle");

    // Reset during W_MSTATUS aborts the sequence
    mstatus_m   = 32'h8;
    inst_i      = ECALL;
    inst_addr_i = 32'h500;
    push(cyc + 1, K_WRITE, 32'h341, 32'h500);
    tick(1'b1, "hold_accept");
    inst_i = NOP;
    tick(1'b1, "hold_seq");
    check("rst_pre_we", {63'd0, we_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_we",       {63'd0, we_o}, 64'd0);
    check("rst_mid_bus",      {waddr_o, data_o}, 64'd0);
    check("rst_mid_redirect", {31'd0, int_assert_o, int_addr_o}, 64'd0);
    check("rst_mid_hold",     {63'd0, hold_flag_o}, 64'd0);
    tick(1'b0, "hold_in_reset");
    tick(1'b0, "hold_in_reset");
    rst    = 1'b1;
    mepc_m = 32'h500;
    idle(4, "hold_idle_after_abort");

    // Randomized operations
    for (int it = 0; it < 40; it++) begin
      mtvec_m = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      op = $urandom_range(0, 5);
      case (op)
        0: trap_seq(T_ECALL, $urandom, 8'h00, 1'($urandom), $urandom, 0, $urandom_range(0, 2), 1'b0);
        1: trap_seq(T_EBREAK, $urandom, 8'h00, 1'($urandom), $urandom, 0, $urandom_range(0, 2), 1'b0);
        2: begin
          if (mstatus_m[3]) begin
            trap_seq(T_INT, $urandom, 8'($urandom_range(1, 255)), 1'($urandom), $urandom,
                     $urandom_range(0, 2), 0, 1'b0);
          end else begin
            int_flag_i = 8'($urandom_range(1, 255));
            idle(3, "hold_int_masked");
            int_flag_i = 8'h00;
          end
        end
        3: mret_seq();
        4: begin
          mstatus_m = $urandom;
          inst_i    = $urandom;
          if (inst_i == ECALL || inst_i == EBREAK || inst_i == MRET) inst_i = NOP;
          inst_addr_i = $urandom;
          tick(1'b0, "hold_non_trap_inst");
        end
        default: trap_seq(T_ECALL, $urandom, 8'($urandom_range(1, 255)), 1'($urandom), $urandom,
                          0, 0, 1'b0);
      endcase
      set_nop();
      idle(1, "hold_idle");
    end

    idle(2, "hold_idle");
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
